adc_frame_capture: RTL

SPI master that reads one complete conversion frame from an ADS1299-class 24-bit biopotential ADC each time the converter signals data-ready. Each frame is one status word followed by NUM_CH channel words. The block converts the frame into the per-channel sample stream consumed by the cursor core (`raw_adc_in`, `adc_channel_sel`, `adc_data_ready`). It sits directly upstream of `boreal_cursor_top`, between the ADC pins and the core.

---
 rtl/adc_frame_capture.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/adc_frame_capture.sv
// adc_frame_capture
// SPI master (mode 1) that reads one conversion frame from an ADS1299-class
// 24-bit ADC on every data-ready falling edge. A frame is one status word
// followed by NUM_CH channel words. Each channel word is presented as a
// one-cycle sample strobe for the cursor core.
//
// Optional feature macro: ADC_STATUS_CHECK_EN
//   When defined, status_word[23:20] must read 4'b1100. A mismatch pulses
//   sync_error and suppresses every channel strobe of that frame.
//
// Parameters
//   CLK_DIV  SCLK half-period in clk cycles (2..255)
//   NUM_CH   channel words per frame (1..8)
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   drdy_n            ADC data-ready, active-low, asynchronous
//   spi_miso          ADC serial data
//   clr_overrun       one-cycle pulse clearing frame_overrun
//   spi_sclk/spi_cs_n SPI clock (CPOL=0, CPHA=1) and chip select
//   raw_adc_in        last channel word
//   adc_channel_sel   channel index of raw_adc_in
//   adc_data_ready    one-cycle strobe qualifying raw_adc_in/adc_channel_sel
//   status_word       status word of the last frame
//   frame_overrun     sticky: drdy_n fell while a frame was in progress
//   sync_error        one-cycle strobe on a status header mismatch
module adc_frame_capture #(
  parameter int CLK_DIV = 4,
  parameter int NUM_CH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        drdy_n,
  input  logic        spi_miso,
  input  logic        clr_overrun,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic [23:0] raw_adc_in,
  output logic [2:0]  adc_channel_sel,
  output logic        adc_data_ready,
  output logic [23:0] status_word,
  output logic        frame_overrun,
  output logic        sync_error
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CS_SETUP = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_CS_HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  // Word counter value once the last channel word has been shifted in.
  localparam logic [3:0] LAST_WORD = 4'(NUM_CH + 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic        sync1_r;
  logic        sync2_r;
  logic        hist_r;
  logic [1:0]  settle_r;
  logic        fall_r;
  logic [7:0]  div_cnt_r;
  logic        div_done_s;
  logic        sclk_r;
  logic        sclk_s;
  logic        cs_n_r;
  logic        cs_n_s;
  logic [22:0] shift_r;
  logic [23:0] word_s;
  logic [4:0]  bit_cnt_r;
  logic [3:0]  word_cnt_r;
  logic        sample_s;
  logic        word_end_s;
  logic        fwd_ok_s;
  logic [23:0] raw_r;
  logic [2:0]  sel_r;
  logic        ready_r;
  logic [23:0] status_r;
  logic        overrun_r;

  assign div_done_s = (div_cnt_r == DIV_LAST);
  // The cycle in which sclk is driven 1->0 is the sampling cycle.
  assign sample_s   = (state_r == ST_SHIFT) & sclk_r & div_done_s;
  assign word_s     = {shift_r, spi_miso};
  assign word_end_s = sample_s & (bit_cnt_r == 5'd23);

`ifdef ADC_STATUS_CHECK_EN
  logic suppress_r;
  logic sync_err_r;
  assign fwd_ok_s   = ~suppress_r;
  assign sync_error = sync_err_r;

  // Status header check; a bad header mutes the rest of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      suppress_r <= 1'b0;
      sync_err_r <= 1'b0;
    end else begin
      sync_err_r <= word_end_s & (word_cnt_r == 4'd0) & (word_s[23:20] != 4'b1100);
      if (state_r == ST_IDLE) begin
        suppress_r <= 1'b0;
      end else if (word_end_s && (word_cnt_r == 4'd0) && (word_s[23:20] != 4'b1100)) begin
        suppress_r <= 1'b1;
      end
    end
  end
`else
  assign fwd_ok_s   = 1'b1;
  assign sync_error = 1'b0;
`endif

  // drdy_n synchronizer with registered falling-edge detect. The history bit
  // stays low until the synchronizer has flushed after reset, so a drdy_n
  // already low at reset release is never seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r  <= 1'b1;
      sync2_r  <= 1'b1;
      hist_r   <= 1'b0;
      settle_r <= 2'd0;
      fall_r   <= 1'b0;
    end else begin
      sync1_r <= drdy_n;
      sync2_r <= sync1_r;
      if (settle_r != 2'd3) begin
        settle_r <= settle_r + 2'd1;
      end
      hist_r <= (settle_r == 2'd3) ? sync2_r : 1'b0;
      fall_r <= hist_r & ~sync2_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fall_r) state_nxt_s = ST_CS_SETUP;
        else        state_nxt_s = ST_IDLE;
      end
      ST_CS_SETUP: begin
        if (div_done_s) state_nxt_s = ST_SHIFT;
        else            state_nxt_s = ST_CS_SETUP;
      end
      ST_SHIFT: begin
        // Leave after the low phase that follows the final sample.
        if (div_done_s && !sclk_r && (word_cnt_r == LAST_WORD)) state_nxt_s = ST_CS_HOLD;
        else                                                    state_nxt_s = ST_SHIFT;
      end
      ST_CS_HOLD: begin
        if (div_done_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_CS_HOLD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered SPI pins.
  always_comb begin
    cs_n_s = (state_nxt_s == ST_IDLE);
    sclk_s = 1'b0;
    case (state_r)
      ST_CS_SETUP: sclk_s = div_done_s;
      ST_SHIFT: begin
        if (div_done_s) sclk_s = ~sclk_r & (state_nxt_s == ST_SHIFT);
        else            sclk_s = sclk_r;
      end
      default: sclk_s = 1'b0;
    endcase
  end

  // Phase timing, shift register, counters, output registers and overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n_r     <= 1'b1;
      sclk_r     <= 1'b0;
      div_cnt_r  <= 8'd0;
      shift_r    <= 23'd0;
      bit_cnt_r  <= 5'd0;
      word_cnt_r <= 4'd0;
      raw_r      <= 24'd0;
      sel_r      <= 3'd0;
      ready_r    <= 1'b0;
      status_r   <= 24'd0;
      overrun_r  <= 1'b0;
    end else begin
      cs_n_r <= cs_n_s;
      sclk_r <= sclk_s;
      if ((state_r == ST_IDLE) || div_done_s) div_cnt_r <= 8'd0;
      else                                    div_cnt_r <= div_cnt_r + 8'd1;

      if (state_r == ST_IDLE) begin
        bit_cnt_r  <= 5'd0;
        word_cnt_r <= 4'd0;
      end else if (sample_s) begin
        shift_r <= word_s[22:0];
        if (bit_cnt_r == 5'd23) begin
          bit_cnt_r  <= 5'd0;
          word_cnt_r <= word_cnt_r + 4'd1;
        end else begin
          bit_cnt_r <= bit_cnt_r + 5'd1;
        end
      end

      ready_r <= 1'b0;
      if (word_end_s) begin
        if (word_cnt_r == 4'd0) begin
          status_r <= word_s;
        end else if (fwd_ok_s) begin
          raw_r   <= word_s;
          sel_r   <= word_cnt_r[2:0] - 3'd1;
          ready_r <= 1'b1;
        end
      end

      // A new edge while busy is dropped but recorded; set beats clear.
      overrun_r <= (fall_r & (state_r != ST_IDLE)) | (overrun_r & ~clr_overrun);
    end
  end

  assign spi_cs_n        = cs_n_r;
  assign spi_sclk        = sclk_r;
  assign raw_adc_in      = raw_r;
  assign adc_channel_sel = sel_r;
  assign adc_data_ready  = ready_r;
  assign status_word     = status_r;
  assign frame_overrun   = overrun_r;

endmodule
